// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle CPU data port.
// Word-addressed RAM plus a peripheral page holding OUT, CYCLE and, when the
// DMEM_TIMER_EN macro is defined, the compare timer (TCMP/TSTAT/TCNT).
// Reads are combinational; writes and status updates land on the rising edge.
module dmem_responder #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic [31:0] outPort,
  output logic        timerIrq,
  output logic        badAccess
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [29:0] OUT_W   = 30'h3FFF_C000;
  localparam logic [29:0] CYC_W   = 30'h3FFF_C001;
`ifdef DMEM_TIMER_EN
  localparam logic [29:0] TCMP_W  = 30'h3FFF_C002;
  localparam logic [29:0] TSTAT_W = 30'h3FFF_C003;
  localparam logic [29:0] TCNT_W  = 30'h3FFF_C004;
`endif

  logic [29:0] word;
  logic        ram_sel, out_sel, cyc_sel, mapped, ram_we;
  logic [31:0] mem [DEPTH];

  logic [31:0] out_q, out_d;
  logic [31:0] cyc_q, cyc_d;
  logic        bad_q, bad_d;

`ifdef DMEM_TIMER_EN
  logic        tcmp_sel, tstat_sel, tcnt_sel;
  logic [31:0] tcmp_q, tcmp_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        flag_q, flag_d;
  logic        en_q, en_d;
`endif

  // Address decode for the RAM window and the peripheral page.
  always_comb begin
    word    = addr[31:2];
    ram_sel = (addr[31:AW+2] == '0);
    out_sel = (word == OUT_W);
    cyc_sel = (word == CYC_W);
    mapped  = ram_sel || out_sel || cyc_sel;
`ifdef DMEM_TIMER_EN
    tcmp_sel  = (word == TCMP_W);
    tstat_sel = (word == TSTAT_W);
    tcnt_sel  = (word == TCNT_W);
    mapped    = mapped || tcmp_sel || tstat_sel || tcnt_sel;
`endif
    // Writes arriving while reset is held are dropped, RAM included.
    ram_we  = memWrite && ram_sel && !reset;
  end

  // Combinational read mux; unmapped addresses return zero.
  always_comb begin
    readData = '0;
    if (ram_sel)        readData = mem[addr[AW+1:2]];
    else if (out_sel)   readData = out_q;
    else if (cyc_sel)   readData = cyc_q;
`ifdef DMEM_TIMER_EN
    else if (tcmp_sel)  readData = tcmp_q;
    else if (tstat_sel) readData = {30'b0, en_q, flag_q};
    else if (tcnt_sel)  readData = tcnt_q;
`endif
  end

  // Next-state for OUT, the cycle counter and the sticky bad-access flag.
  always_comb begin
    out_d = out_q;
    if (memWrite && out_sel) out_d = writeData;
    cyc_d = cyc_q + 32'd1;
    bad_d = bad_q || !mapped;
  end

`ifdef DMEM_TIMER_EN
  // Timer next-state: a TCNT write overrides the count and suppresses the
  // match; a match sets the flag even when the same write clears it, and
  // compares against TCMP as it was before this cycle's write.
  always_comb begin
    tcmp_d = tcmp_q;
    tcnt_d = tcnt_q;
    flag_d = flag_q;
    en_d   = en_q;
    if (en_q) tcnt_d = (tcnt_q == tcmp_q) ? '0 : tcnt_q + 32'd1;
    if (memWrite && tstat_sel) begin
      en_d = writeData[1];
      if (writeData[0]) flag_d = 1'b0;
    end
    if (memWrite && tcmp_sel) tcmp_d = writeData;
    if (memWrite && tcnt_sel) tcnt_d = writeData;
    else if (en_q && (tcnt_q == tcmp_q)) flag_d = 1'b1;
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcmp_q <= '1;
      tcnt_q <= '0;
      flag_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      tcmp_q <= tcmp_d;
      tcnt_q <= tcnt_d;
      flag_q <= flag_d;
      en_q   <= en_d;
    end
  end

  assign timerIrq = flag_q;
`else
  assign timerIrq = 1'b0;
`endif

  // Peripheral and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      cyc_q <= '0;
      bad_q <= 1'b0;
    end else begin
      out_q <= out_d;
      cyc_q <= cyc_d;
      bad_q <= bad_d;
    end
  end

  // Data RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[addr[AW+1:2]] <= writeData;
  end

  assign outPort   = out_q;
  assign badAccess = bad_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. A cycle-level model built from the
// address map and timer rules is compared against the DUT on every falling
// edge; directed steps add literal expectations. Honours DMEM_TIMER_EN.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
`ifdef DMEM_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  localparam logic [31:0] A_OUT   = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC   = 32'hFFFF_0004;
  localparam logic [31:0] A_TCMP  = 32'hFFFF_0008;
  localparam logic [31:0] A_TSTAT = 32'hFFFF_000C;
  localparam logic [31:0] A_TCNT  = 32'hFFFF_0010;
  localparam logic [31:0] A_BAD   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        memWrite;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic [31:0] outPort;
  logic        timerIrq;
  logic        badAccess;

  int tests = 0;
  int fails = 0;

  dmem_responder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .memWrite  (memWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData),
    .outPort   (outPort),
    .timerIrq  (timerIrq),
    .badAccess (badAccess)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef enum int {R_RAM, R_OUT, R_CYC, R_TCMP, R_TSTAT, R_TCNT, R_BAD} region_e;

  typedef struct {
    logic [31:0] out;
    logic [31:0] cycle;
    logic [31:0] tcmp;
    logic [31:0] tcnt;
    bit          flag;
    bit          en;
    bit          bad;
  } mstate_t;

  mstate_t     ms;
  logic [31:0] m_ram [DEPTH];
  bit          m_val [DEPTH];

  function automatic region_e region(input logic [31:0] a);
    if (a < DEPTH * 4) return R_RAM;
    case (a & 32'hFFFF_FFFC)
      A_OUT:   return R_OUT;
      A_CYC:   return R_CYC;
      A_TCMP:  return TIMER ? R_TCMP  : R_BAD;
      A_TSTAT: return TIMER ? R_TSTAT : R_BAD;
      A_TCNT:  return TIMER ? R_TCNT  : R_BAD;
      default: return R_BAD;
    endcase
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic mstate_t rst_state();
    mstate_t s;
    s.out = 0; s.cycle = 0; s.tcmp = 32'hFFFF_FFFF; s.tcnt = 0;
    s.flag = 0; s.en = 0; s.bad = 0;
    return s;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic we,
                                   input logic [31:0] a, input logic [31:0] d);
    mstate_t n = s;
    region_e r = region(a);
    bit hit = 0;
    n.cycle = s.cycle + 1;
    if (r == R_BAD) n.bad = 1;
    if (s.en) begin
      if (s.tcnt == s.tcmp) begin n.tcnt = 0; hit = 1; end
      else n.tcnt = s.tcnt + 1;
    end
    if (we) begin
      case (r)
        R_OUT:   n.out = d;
        R_TCMP:  n.tcmp = d;
        R_TSTAT: begin n.en = d[1]; if (d[0]) n.flag = 0; end
        R_TCNT:  begin n.tcnt = d; hit = 0; end
        default: ;
      endcase
    end
    if (hit) n.flag = 1;
    return n;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (region(a))
      R_RAM:   return m_ram[widx(a)];
      R_OUT:   return ms.out;
      R_CYC:   return ms.cycle;
      R_TCMP:  return ms.tcmp;
      R_TSTAT: return {30'b0, ms.en, ms.flag};
      R_TCNT:  return ms.tcnt;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) ms <= rst_state();
    else begin
      ms <= step(ms, memWrite, addr, writeData);
      if (memWrite && region(addr) == R_RAM) begin
        m_ram[widx(addr)] <= writeData;
        m_val[widx(addr)] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (region(addr) != R_RAM || m_val[widx(addr)])
      chk("cmp_readData", readData, model_read(addr));
    chk("cmp_outPort", outPort, ms.out);
    chk("cmp_timerIrq", {31'b0, timerIrq}, {31'b0, ms.flag});
    chk("cmp_badAccess", {31'b0, badAccess}, {31'b0, ms.bad});
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; writeData = d; memWrite = 1'b1;
    @(posedge clk); #1;
    memWrite = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; memWrite = 1'b0;
    #1;
    chk(name, readData, exp);
  endtask

  initial begin
    memWrite = 1'b0; addr = 32'h0; writeData = 32'h0; reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_outPort", outPort, 32'h0);
    chk("rst_badAccess", {31'b0, badAccess}, 32'h0);
    chk("rst_timerIrq", {31'b0, timerIrq}, 32'h0);
    rd_chk("rst_cycle", A_CYC, 32'h0);
    @(posedge clk);
`ifdef DMEM_TIMER_EN
    rd_chk("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    rd_chk("rst_tstat", A_TSTAT, 32'h0);
`endif
    @(negedge clk);
    addr = A_CYC;
    reset = 1'b0;

    // CYCLE counts edges since reset release; writes are ignored.
    repeat (10) @(posedge clk);
    rd_chk("cycle_10", A_CYC, 32'd10);
    wr(A_CYC, 32'h0000_1000);
    rd_chk("cycle_ro", A_CYC, 32'd11);

    // RAM
    wr(32'h0000_0000, 32'h1111_1111);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_0014, 32'h1234_5678);
    rd_chk("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
    rd_chk("ram_14", 32'h0000_0014, 32'h1234_5678);
    wr(32'h0000_03FC, 32'hCAFE_F00D);
    rd_chk("ram_top", 32'h0000_03FC, 32'hCAFE_F00D);
    rd_chk("ram_0", 32'h0000_0000, 32'h1111_1111);

    // OUT
    wr(A_OUT, 32'h0000_00A5);
    chk("out_port", outPort, 32'h0000_00A5);
    rd_chk("out_rb", A_OUT, 32'h0000_00A5);
    tick();

`ifdef DMEM_TIMER_EN
    // Timer: TCMP=4 gives a match 5 edges after the enable write.
    wr(A_TCMP, 32'd4);
    wr(A_TSTAT, 32'h2);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("irq_edge%0d", k), {31'b0, timerIrq}, (k == 5) ? 32'd1 : 32'd0);
    end
    rd_chk("tcnt_after_match", A_TCNT, 32'h0);
    wr(A_TSTAT, 32'h3);
    chk("irq_cleared", {31'b0, timerIrq}, 32'h0);
    repeat (3) tick();
    wr(A_TSTAT, 32'h3);
    chk("clear_vs_match", {31'b0, timerIrq}, 32'h1);
    rd_chk("tstat_rb", A_TSTAT, 32'h3);
    // Disable and clear, then a TCNT write coinciding with a match wins.
    wr(A_TSTAT, 32'h1);
    chk("irq_clr_dis", {31'b0, timerIrq}, 32'h0);
    wr(A_TCNT, 32'd4);
    wr(A_TSTAT, 32'h2);
    wr(A_TCNT, 32'd9);
    chk("tcnt_write_wins", {31'b0, timerIrq}, 32'h0);
    rd_chk("tcnt_9", A_TCNT, 32'd9);
    wr(A_TSTAT, 32'h0);
    rd_chk("tcnt_10_held", A_TCNT, 32'd10);
    // TCMP write in a match cycle: the match uses the old compare value.
    wr(A_TCNT, 32'd4);
    wr(A_TSTAT, 32'h2);
    wr(A_TCMP, 32'd7);
    chk("tcmp_old_used", {31'b0, timerIrq}, 32'h1);
    rd_chk("tcnt_wrapped", A_TCNT, 32'h0);
    rd_chk("tcmp_new", A_TCMP, 32'd7);
    wr(A_TSTAT, 32'h1);
    chk("bad_none_yet", {31'b0, badAccess}, 32'h0);
`else
    // Timer page is unmapped in this build.
    chk("bad_none_yet", {31'b0, badAccess}, 32'h0);
    rd_chk("notimer_tcmp", A_TCMP, 32'h0);
    tick();
    chk("notimer_bad", {31'b0, badAccess}, 32'h1);
    chk("notimer_irq", {31'b0, timerIrq}, 32'h0);
`endif

    // Unmapped access: reads zero, sticky badAccess, write has no effect.
    rd_chk("unmapped_rd", A_BAD, 32'h0);
    tick();
    chk("bad_set", {31'b0, badAccess}, 32'h1);
    addr = 32'h0000_0010;
    tick();
    chk("bad_sticky", {31'b0, badAccess}, 32'h1);
    wr(A_BAD, 32'h0000_0055);
    rd_chk("unmapped_ram0", 32'h0000_0000, 32'h1111_1111);
    rd_chk("unmapped_ram10", 32'h0000_0010, 32'hDEAD_BEEF);
    chk("unmapped_out", outPort, 32'h0000_00A5);
    tick();
`ifdef DMEM_TIMER_EN
    rd_chk("unmapped_tcmp", A_TCMP, 32'd7);
`endif
    rd_chk("unmapped_outrb", A_OUT, 32'h0000_00A5);
    tick();

    // Mid-cycle asynchronous reset with a pending write.
    addr = A_OUT; writeData = 32'h0000_0077; memWrite = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out", outPort, 32'h0);
    chk("async_rst_bad", {31'b0, badAccess}, 32'h0);
    chk("async_rst_irq", {31'b0, timerIrq}, 32'h0);
    @(posedge clk); #1;
    memWrite = 1'b0; addr = A_CYC;
    #2 reset = 1'b0;
    tick();
    chk("rst_write_dropped", outPort, 32'h0);
    rd_chk("cycle_after_rst", A_CYC, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
